// File: rtl/ifq_fetch_queue.sv
// Fetch-to-decode decoupling queue: in-order circular buffer with valid/ready
// on both sides, flush on redirect, and push blocking once a trapping entry is queued.
module ifq_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int TRAP_W = 16,
    parameter int HIS_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [31:0]              in_pc_i,
    input  logic [31:0]              in_inst_i,
    input  logic                     in_is_c_i,
    input  logic                     in_pdt_res_i,
    input  logic [31:0]              in_pdt_tag_i,
    input  logic [HIS_W-1:0]         in_history_i,
    input  logic [TRAP_W-1:0]        in_trap_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [31:0]              out_pc_o,
    output logic [31:0]              out_inst_o,
    output logic                     out_is_c_o,
    output logic                     out_pdt_res_o,
    output logic [31:0]              out_pdt_tag_o,
    output logic [HIS_W-1:0]         out_history_o,
    output logic [TRAP_W-1:0]        out_trap_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     trap_block_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = 32 + 32 + 1 + 1 + 32 + HIS_W + TRAP_W;
    localparam logic [PW:0] FULL_C = (PW + 1)'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          trap_block_q, trap_block_d;

    logic [EW-1:0] entry_mem_q [DEPTH];
    logic [EW-1:0] in_entry;
    logic [EW-1:0] head_entry;

    logic push;
    logic pop;

    assign in_ready_o   = (count_q != FULL_C) & ~trap_block_q;
    assign out_valid_o  = (count_q != '0);
    assign count_o      = count_q;
    assign trap_block_o = trap_block_q;

    assign push = in_valid_i & in_ready_o & ~flush_i;
    assign pop  = out_valid_o & out_ready_i & ~flush_i;

    assign in_entry = {in_pc_i, in_inst_i, in_is_c_i, in_pdt_res_i,
                       in_pdt_tag_i, in_history_i, in_trap_i};

    // Entry RAM is never reset, so the head is masked to zero while empty.
    assign head_entry = out_valid_o ? entry_mem_q[rd_ptr_q] : '0;

    assign {out_pc_o, out_inst_o, out_is_c_o, out_pdt_res_o,
            out_pdt_tag_o, out_history_o, out_trap_o} = head_entry;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        trap_block_d = trap_block_q;
        if (flush_i) begin
            rd_ptr_d     = wr_ptr_q;
            count_d      = '0;
            trap_block_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (|in_trap_i) begin
                    trap_block_d = 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            trap_block_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            trap_block_q <= trap_block_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entry_mem_q[wr_ptr_q] <= in_entry;
        end
    end

endmodule

// File: tb/tb_ifq_fetch_queue.sv
// Self-checking bench for ifq_fetch_queue: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_ifq_fetch_queue;

    localparam int DEPTH  = 4;
    localparam int TRAP_W = 16;
    localparam int HIS_W  = 8;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       inst;
        logic              is_c;
        logic              pres;
        logic [31:0]       tag;
        logic [HIS_W-1:0]  his;
        logic [TRAP_W-1:0] trap;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush_i = 1'b0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [31:0]       in_pc_i = '0;
    logic [31:0]       in_inst_i = '0;
    logic              in_is_c_i = 1'b0;
    logic              in_pdt_res_i = 1'b0;
    logic [31:0]       in_pdt_tag_i = '0;
    logic [HIS_W-1:0]  in_history_i = '0;
    logic [TRAP_W-1:0] in_trap_i = '0;
    logic              out_valid_o;
    logic              out_ready_i = 1'b0;
    logic [31:0]       out_pc_o;
    logic [31:0]       out_inst_o;
    logic              out_is_c_o;
    logic              out_pdt_res_o;
    logic [31:0]       out_pdt_tag_o;
    logic [HIS_W-1:0]  out_history_o;
    logic [TRAP_W-1:0] out_trap_o;
    logic [$clog2(DEPTH):0] count_o;
    logic              trap_block_o;

    ifq_fetch_queue #(.DEPTH(DEPTH), .TRAP_W(TRAP_W), .HIS_W(HIS_W)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_pc_i(in_pc_i), .in_inst_i(in_inst_i), .in_is_c_i(in_is_c_i),
        .in_pdt_res_i(in_pdt_res_i), .in_pdt_tag_i(in_pdt_tag_i),
        .in_history_i(in_history_i), .in_trap_i(in_trap_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_pc_o(out_pc_o), .out_inst_o(out_inst_o), .out_is_c_o(out_is_c_o),
        .out_pdt_res_o(out_pdt_res_o), .out_pdt_tag_o(out_pdt_tag_o),
        .out_history_o(out_history_o), .out_trap_o(out_trap_o),
        .count_o(count_o), .trap_block_o(trap_block_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue contents and the trap-blocked flag.
    ent_t        mq[$];
    bit          m_tb = 1'b0;
    bit          started = 1'b0;
    logic [31:0] poplog[$];

    always @(posedge clk) begin
        bit   rdy;
        bit   vld;
        ent_t e;
        ent_t h;
        if (rst) begin
            mq.delete();
            m_tb    = 1'b0;
            started = 1'b1;
        end else if (started) begin
            if (flush_i) begin
                mq.delete();
                m_tb = 1'b0;
            end else begin
                rdy = (mq.size() < DEPTH) && !m_tb;
                vld = (mq.size() != 0);
                if (vld && out_ready_i) begin
                    h = mq.pop_front();
                    poplog.push_back(h.pc);
                    $display("pop pc=%h inst=%h trap=%h", h.pc, h.inst, h.trap);
                end
                if (in_valid_i && rdy) begin
                    e = '{pc: in_pc_i, inst: in_inst_i, is_c: in_is_c_i, pres: in_pdt_res_i,
                          tag: in_pdt_tag_i, his: in_history_i, trap: in_trap_i};
                    mq.push_back(e);
                    if (in_trap_i != '0) m_tb = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", 64'(in_ready_o), 64'((mq.size() < DEPTH) && !m_tb));
            chk("out_valid", 64'(out_valid_o), 64'(mq.size() != 0));
            chk("count", 64'(count_o), 64'(mq.size()));
            chk("trap_block", 64'(trap_block_o), 64'(m_tb));
            if (mq.size() != 0) begin
                chk("head_pc", 64'(out_pc_o), 64'(mq[0].pc));
                chk("head_inst", 64'(out_inst_o), 64'(mq[0].inst));
                chk("head_misc",
                    64'({out_is_c_o, out_pdt_res_o, out_pdt_tag_o, out_history_o, out_trap_o}),
                    64'({mq[0].is_c, mq[0].pres, mq[0].tag, mq[0].his, mq[0].trap}));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input logic [31:0] pc, input logic [TRAP_W-1:0] trap);
        in_valid_i   = v;
        in_pc_i      = pc;
        in_inst_i    = $urandom;
        in_is_c_i    = 1'($urandom);
        in_pdt_res_i = 1'($urandom);
        in_pdt_tag_i = $urandom;
        in_history_i = HIS_W'($urandom);
        in_trap_i    = trap;
    endtask

    // Presents an entry and holds it until the queue accepts it.
    task automatic push(input logic [31:0] pc, input logic [TRAP_W-1:0] trap);
        int n = 0;
        set_in(1'b1, pc, trap);
        while (!in_ready_o && n < 50) begin
            cyc();
            n++;
        end
        chk("push_accept", 64'(in_ready_o), 64'(1));
        cyc();
        in_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid_i = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_count", 64'(count_o), 64'(0));
        chk("rst_out_valid", 64'(out_valid_o), 64'(0));
        chk("rst_in_ready", 64'(in_ready_o), 64'(1));
        chk("rst_trap_block", 64'(trap_block_o), 64'(0));
        chk("rst_out_pc", 64'(out_pc_o), 64'(0));
        chk("rst_out_inst", 64'(out_inst_o), 64'(0));

        // Single transfer with one cycle of latency.
        out_ready_i = 1'b1;
        set_in(1'b1, 32'h8000_0000, '0);
        in_inst_i = 32'h0000_0013;
        cyc();
        in_valid_i = 1'b0;
        chk("single_valid", 64'(out_valid_o), 64'(1));
        chk("single_pc", 64'(out_pc_o), 64'h8000_0000);
        chk("single_inst", 64'(out_inst_o), 64'h0000_0013);
        chk("single_count1", 64'(count_o), 64'(1));
        cyc();
        chk("single_count0", 64'(count_o), 64'(0));
        chk("single_empty", 64'(out_valid_o), 64'(0));

        // Fill to full, then wrap with concurrent push and pop.
        poplog.delete();
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h8000_0000 + 32'(4 * i), '0);
        chk("full_count", 64'(count_o), 64'(4));
        chk("full_in_ready", 64'(in_ready_o), 64'(0));
        out_ready_i = 1'b1;
        for (int i = 4; i < 8; i++) push(32'h8000_0000 + 32'(4 * i), '0);
        idle(8);
        chk("wrap_pop_count", 64'(poplog.size()), 64'(8));
        for (int i = 0; i < 8 && i < poplog.size(); i++)
            chk("wrap_order", 64'(poplog[i]), 64'h8000_0000 + 64'(4 * i));

        // Steady state at count 2 with push and pop every cycle.
        out_ready_i = 1'b0;
        push(32'h8000_0100, '0);
        push(32'h8000_0104, '0);
        out_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 32'h8000_0108 + 32'(4 * i), '0);
            cyc();
            chk("steady_count", 64'(count_o), 64'(2));
        end
        idle(4);

        // Flush with three entries held and a push in the same cycle.
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) push(32'h8000_0200 + 32'(4 * i), '0);
        flush_i = 1'b1;
        set_in(1'b1, 32'h8000_0F00, '0);
        cyc();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        chk("flush_count", 64'(count_o), 64'(0));
        chk("flush_valid", 64'(out_valid_o), 64'(0));
        poplog.delete();
        out_ready_i = 1'b1;
        push(32'h8000_1000, '0);
        idle(3);
        chk("flush_first_out", 64'(poplog.size() > 0 ? poplog[0] : 32'h0), 64'h8000_1000);

        // Trap blocking: only the trapping entry gets through.
        poplog.delete();
        out_ready_i = 1'b0;
        push(32'h8000_2000, 16'h0002);
        set_in(1'b1, 32'h8000_2004, '0);
        cyc();
        set_in(1'b1, 32'h8000_2008, '0);
        cyc();
        chk("trap_in_ready", 64'(in_ready_o), 64'(0));
        chk("trap_block", 64'(trap_block_o), 64'(1));
        chk("trap_count", 64'(count_o), 64'(1));
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        in_valid_i = 1'b0;
        chk("trap_pops", 64'(poplog.size()), 64'(1));
        chk("trap_pop_pc", 64'(poplog.size() > 0 ? poplog[0] : 32'h0), 64'h8000_2000);
        chk("trap_sticky", 64'(trap_block_o), 64'(1));
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        chk("trap_clr_ready", 64'(in_ready_o), 64'(1));
        chk("trap_clr_block", 64'(trap_block_o), 64'(0));

        // Reset while full and trap-blocked.
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) push(32'h8000_3000 + 32'(4 * i), '0);
        push(32'h8000_300C, 16'h8000);
        chk("pre_rst_count", 64'(count_o), 64'(4));
        chk("pre_rst_block", 64'(trap_block_o), 64'(1));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_count", 64'(count_o), 64'(0));
        chk("mid_rst_valid", 64'(out_valid_o), 64'(0));
        chk("mid_rst_ready", 64'(in_ready_o), 64'(1));
        chk("mid_rst_block", 64'(trap_block_o), 64'(0));

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 499) == 0);
            flush_i = ($urandom_range(0, 39) == 0);
            set_in($urandom_range(0, 3) != 0, $urandom,
                   ($urandom_range(0, 15) == 0) ? TRAP_W'($urandom_range(1, 65535)) : '0);
            out_ready_i = ($urandom_range(0, 2) != 0);
            cyc();
        end
        rst        = 1'b0;
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
